add16_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one 16-bit adder-with-flags datapath (sum plus sign/zero/carry/parity/overflow) between two requesters. It accepts one operand pair at a time over a valid/ready handshake and registers operands, result and flags. It returns the result with a requester ID over a valid/ready response channel. It sits between the two client blocks and the shared ALU adder, and is the only block that drives the adder's operand inputs.

---
 rtl/add16_arbiter_if.sv | 39 +++
 rtl/add16_arbiter.sv | 148 ++++++++++++++
 tb/tb_add16_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add16_arbiter_if.sv
// add16_arbiter_if: request/response bundle between two requesters, one
// response consumer and the add16_arbiter.
// master: the client side (requesters and response consumer).
// slave: the arbiter side.
interface add16_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;

  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_sum;
  logic [4:0]  rsp_flags;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_flags,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/add16_arbiter.sv
// add16_arbiter: shares one 16-bit adder-with-flags between two requesters.
// Operates as IDLE (arbitrate) -> EXEC (add latched operands) -> DONE (hold
// response until consumed).
// rsp_flags = {sign, zero, carry, parity, overflow}.
// Optional macro ADD16_ARB_FIXED_PRIO_EN:
//   defined   -> requester 0 always wins a tie.
//   undefined -> round-robin using a last-grant register that resets to 1.
module add16_arbiter (
  input logic            clk,
  input logic            rst,
  add16_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] opA_q, opA_d;
  logic [15:0] opB_q, opB_d;
  logic        opId_q, opId_d;
  logic        rspValid_q, rspValid_d;
  logic        rspId_q, rspId_d;
  logic [15:0] rspSum_q, rspSum_d;
  logic [4:0]  rspFlags_q, rspFlags_d;
`ifndef ADD16_ARB_FIXED_PRIO_EN
  logic        lastGrant_q, lastGrant_d;
`endif

  logic        anyValid;
  logic        grantId;
  logic        grantOk;
  logic [16:0] sumFull;
  logic [15:0] sum;
  logic [4:0]  flags;

  // Grant selection: ready is offered only in IDLE, never during reset, and
  // never depends on the response side.
  always_comb begin
    anyValid = bus.req0_valid | bus.req1_valid;
`ifdef ADD16_ARB_FIXED_PRIO_EN
    grantId = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      grantId = ~lastGrant_q;
    end else begin
      grantId = ~bus.req0_valid;
    end
`endif
    grantOk = (state_q == IDLE) && !rst && anyValid;
  end

  assign bus.req0_ready = grantOk && !grantId;
  assign bus.req1_ready = grantOk && grantId;

  // Shared adder and its flags, fed only from the latched operands.
  always_comb begin
    sumFull = {1'b0, opA_q} + {1'b0, opB_q};
    sum     = sumFull[15:0];
    flags   = {sum[15],
               (sum == 16'h0000),
               sumFull[16],
               ~^sum,
               (opA_q[15] == opB_q[15]) && (sum[15] != opA_q[15])};
  end

  // Next-state logic for the sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    opId_d      = opId_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspSum_d    = rspSum_q;
    rspFlags_d  = rspFlags_q;
`ifndef ADD16_ARB_FIXED_PRIO_EN
    lastGrant_d = lastGrant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grantOk) begin
          opA_d   = grantId ? bus.req1_a : bus.req0_a;
          opB_d   = grantId ? bus.req1_b : bus.req0_b;
          opId_d  = grantId;
`ifndef ADD16_ARB_FIXED_PRIO_EN
          lastGrant_d = grantId;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        rspSum_d   = sum;
        rspFlags_d = flags;
        rspId_d    = opId_q;
        rspValid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        rspValid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= 16'h0000;
      opB_q       <= 16'h0000;
      opId_q      <= 1'b0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspSum_q    <= 16'h0000;
      rspFlags_q  <= 5'b00000;
`ifndef ADD16_ARB_FIXED_PRIO_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opId_q      <= opId_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspSum_q    <= rspSum_d;
      rspFlags_q  <= rspFlags_d;
`ifndef ADD16_ARB_FIXED_PRIO_EN
      lastGrant_q <= lastGrant_d;
`endif
    end
  end

  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_id    = rspId_q;
  assign bus.rsp_sum   = rspSum_q;
  assign bus.rsp_flags = rspFlags_q;

endmodule

// File: tb/tb_add16_arbiter.sv
// tb_add16_arbiter: directed vectors with hand-computed results; a separate
// monitor pops expected responses from a queue when the DUT delivers one.
module tb_add16_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  add16_arbiter_if ifc ();

  add16_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic [4:0]  flags;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;

  // Free-running cycle count used to measure grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks responses stay stable while stalled and scores each
  // consumed response against the oldest expected entry.
  logic        held = 1'b0;
  logic        heldId;
  logic [15:0] heldSum;
  logic [4:0]  heldFlags;
  exp_t        monE;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else if (ifc.rsp_valid) begin
        if (held) begin
          checkOutput("stable_id", ifc.rsp_id, heldId);
          checkOutput("stable_sum", ifc.rsp_sum, heldSum);
          checkOutput("stable_flags", ifc.rsp_flags, heldFlags);
        end else begin
          held      = 1'b1;
          heldId    = ifc.rsp_id;
          heldSum   = ifc.rsp_sum;
          heldFlags = ifc.rsp_flags;
        end
        if (ifc.rsp_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 1, 0);
          end else begin
            monE = expQ.pop_front();
            checkOutput("rsp_id", ifc.rsp_id, monE.id);
            checkOutput("rsp_sum", ifc.rsp_sum, monE.sum);
            checkOutput("rsp_flags", ifc.rsp_flags, monE.flags);
          end
          held = 1'b0;
        end
      end
    end
  end

  // Issues one request from a single requester starting in IDLE, pushes the
  // hand-computed result at the handshake and measures response latency.
  task automatic applyStimulus(input logic id, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expSum, input logic [4:0] expFlags);
    exp_t e;
    int   lat;
    bit   hs;
    if (id) begin
      ifc.req1_a = a; ifc.req1_b = b; ifc.req1_valid = 1'b1;
    end else begin
      ifc.req0_a = a; ifc.req0_b = b; ifc.req0_valid = 1'b1;
    end
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("req_ready_first", id ? ifc.req1_ready : ifc.req0_ready, 1);
      if (id ? (ifc.req1_valid && ifc.req1_ready) : (ifc.req0_valid && ifc.req0_ready)) hs = 1'b1;
    end
    if (!hs) begin
      checkOutput("hs_timeout", 0, 1);
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b0;
      return;
    end
    e.id = id; e.sum = expSum; e.flags = expFlags;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (id) ifc.req1_valid = 1'b0;
    else    ifc.req0_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ifc.rsp_valid && lat < 10);
    checkOutput("rsp_latency", lat, 2);
  endtask

  // Waits until a response is consumed, then steps just past the next edge.
  task automatic waitRsp();
    int k;
    k = 0;
    while (!(ifc.rsp_valid && ifc.rsp_ready) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) checkOutput("rsp_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] expOrder;
  int         nGrant;
  int         lastCyc;
  logic       gid;
  exp_t       e;

  initial begin
    ifc.req0_valid = 1'b0; ifc.req0_a = 16'h0; ifc.req0_b = 16'h0;
    ifc.req1_valid = 1'b0; ifc.req1_a = 16'h0; ifc.req1_b = 16'h0;
    ifc.rsp_ready  = 1'b1;

    // Reset values, with both requesters asserting valid during reset.
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", ifc.rsp_valid, 0);
    checkOutput("reset_rsp_id", ifc.rsp_id, 0);
    checkOutput("reset_rsp_sum", ifc.rsp_sum, 0);
    checkOutput("reset_rsp_flags", ifc.rsp_flags, 0);
    checkOutput("reset_req0_ready", ifc.req0_ready, 0);
    checkOutput("reset_req1_ready", ifc.req1_ready, 0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Signed overflow into the sign bit.
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10001);
    waitRsp();
    // Unsigned wrap to zero from requester 1.
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110);
    waitRsp();

    // Both requesters valid continuously from reset.
`ifdef ADD16_ARB_FIXED_PRIO_EN
    expOrder = 4'b0000;
`else
    expOrder = 4'b1010;
`endif
    #1 rst = 1'b1;
    ifc.req0_a = 16'h0001; ifc.req0_b = 16'h0002; ifc.req0_valid = 1'b1;
    ifc.req1_a = 16'h8000; ifc.req1_b = 16'h8000; ifc.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nGrant  = 0;
    lastCyc = 0;
    for (int k = 0; k < 40 && nGrant < 4; k++) begin
      @(negedge clk);
      if (ifc.req0_ready && ifc.req1_ready) checkOutput("both_ready", 1, 0);
      if (ifc.req0_ready || ifc.req1_ready) begin
        gid = ifc.req1_ready;
        checkOutput("grant_id", gid, expOrder[nGrant]);
        if (nGrant > 0) checkOutput("grant_spacing", cyc - lastCyc, 3);
        lastCyc = cyc;
        if (expOrder[nGrant]) begin
          e.id = 1'b1; e.sum = 16'h0000; e.flags = 5'b01111;
        end else begin
          e.id = 1'b0; e.sum = 16'h0003; e.flags = 5'b00010;
        end
        expQ.push_back(e);
        nGrant++;
      end
    end
    if (nGrant < 4) checkOutput("rr_grant_count", nGrant, 4);
    @(posedge clk);
    #1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    waitRsp();

    // Backpressure in DONE while requester 1 waits.
    ifc.rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h1111, 16'h2222, 16'h3333, 5'b00010);
    @(posedge clk);
    #1;
    ifc.req1_a = 16'h0005; ifc.req1_b = 16'h0003; ifc.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_req1_ready", ifc.req1_ready, 0);
      checkOutput("bp_rsp_valid", ifc.rsp_valid, 1);
    end
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_req1_ready_done", ifc.req1_ready, 0);
    @(negedge clk);
    checkOutput("bp_grant_after_release", ifc.req1_ready, 1);
    e.id = 1'b1; e.sum = 16'h0008; e.flags = 5'b00000;
    expQ.push_back(e);
    @(posedge clk);
    #1 ifc.req1_valid = 1'b0;
    waitRsp();

    // Reset while the adder is in EXEC: the operation is dropped.
    ifc.req0_a = 16'hAAAA; ifc.req0_b = 16'h0001; ifc.req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_test_grant", ifc.req0_ready, 1);
    @(posedge clk);
    #1;
    ifc.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_exec_rsp_valid", ifc.rsp_valid, 0);
    checkOutput("rst_exec_req0_ready", ifc.req0_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 16'h1234, 16'h4321, 16'h5555, 5'b00010);
    waitRsp();

    repeat (4) @(negedge clk);
    checkOutput("pending_expected", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
